// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with sub-word read-modify-write and load extension.
// Define MEM_ACCESS_STATS_EN to add saturating load/store/error counters.
module mem_access_unit #(
    parameter int ADDR_W      = 10,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       dm_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_we,
    output logic [31:0]       dm_wdata,
    output logic [31:0]       load_data,
    output logic              stall,
`ifdef MEM_ACCESS_STATS_EN
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt,
    output logic [15:0]       err_cnt,
`endif
    output logic              addr_err
);
    typedef enum logic {IDLE, MERGE} state_t;
    state_t state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0] lane;
    logic is_word, is_half, misaligned, out_of_range, err, in_idle;
    logic load_acc, word_store, sub_store;
    logic [7:0] sel_b;
    logic [15:0] sel_h;
    logic [31:0] ext, merged;

    assign word_idx     = req_addr[ADDR_W+1:2];
    assign lane         = req_addr[1:0];
    assign is_word      = req_size[1];
    assign is_half      = req_size == 2'b01;
    assign misaligned   = (is_half & req_addr[0]) | (is_word & |req_addr[1:0]);
    assign out_of_range = RANGE_CHECK && ((req_addr >> (ADDR_W + 2)) != 32'd0);
    assign err          = req_valid & (misaligned | out_of_range);
    assign in_idle      = state_q == IDLE;
    assign load_acc     = in_idle & req_valid & ~req_we & ~err;
    assign word_store   = in_idle & req_valid & req_we & is_word & ~err;
    assign sub_store    = in_idle & req_valid & req_we & ~is_word & ~err;
    assign sel_b        = dm_rdata[{lane, 3'b000} +: 8];
    assign sel_h        = req_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    assign ext          = is_word ? dm_rdata
                        : is_half ? {{16{req_signed & sel_h[15]}}, sel_h}
                        : {{24{req_signed & sel_b[7]}}, sel_b};

    always_comb begin
        merged = dm_rdata;
        if (is_half)
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        else
            merged[{lane, 3'b000} +: 8] = req_wdata[7:0];
    end

    // MERGE replays the word captured in IDLE; the inputs are ignored there.
    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        word_d    = word_q;
        dm_addr   = in_idle ? word_idx : word_q;
        dm_we     = in_idle ? word_store : 1'b1;
        dm_wdata  = in_idle ? req_wdata : merge_q;
        stall     = sub_store;
        addr_err  = in_idle & err;
        load_data = load_acc ? ext : 32'd0;
        if (sub_store) begin
            state_d = MERGE;
            merge_d = merged;
            word_d  = word_idx;
        end
        if (!in_idle)
            state_d = IDLE;
        if (rst) begin
            dm_we     = 1'b0;
            stall     = 1'b0;
            addr_err  = 1'b0;
            load_data = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            word_q  <= word_d;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q + 16'(load_acc && load_cnt_q != 16'hFFFF);
        store_cnt_d = store_cnt_q + 16'((word_store || !in_idle) && store_cnt_q != 16'hFFFF);
        err_cnt_d   = err_cnt_q + 16'(addr_err && err_cnt_q != 16'hFFFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a word-level memory reference model.
module tb_mem_access_unit;
    logic        clk, rst, req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, dm_rdata, dm_wdata, load_data;
    logic [9:0]  dm_addr;
    logic        dm_we, stall, addr_err;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] load_cnt, store_cnt, err_cnt;
`endif

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .dm_rdata(dm_rdata), .dm_addr(dm_addr),
        .dm_we(dm_we), .dm_wdata(dm_wdata), .load_data(load_data),
        .stall(stall),
`ifdef MEM_ACCESS_STATS_EN
        .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt),
`endif
        .addr_err(addr_err)
    );

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mem[1024];
    logic [31:0] ref_mem[1024];
    logic        init_req, poke_en, last_stall;
    logic [9:0]  poke_a;
    logic [31:0] poke_d;
    int          tests, fails, scount, cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    assign dm_rdata = mem[dm_addr];
    always @(negedge clk) begin
        if (init_req)
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        else if (dm_we)
            mem[dm_addr] <= dm_wdata;
        else if (poke_en)
            mem[poke_a] <= poke_d;
    end

    // Byte-oriented reference: lanes picked by shifting the whole word.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int nbytes, sh, idx;
        logic [31:0] w, mask, v, nw;
        nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err   = (a % nbytes != 0) || (a >= 32'h1000);
        e.we    = 1'b0;
        e.addr  = '0;
        e.wdata = '0;
        e.ld    = '0;
        e.stalls = 0;
        idx  = int'((a / 4) % 1024);
        sh   = int'(a % 4) * 8;
        w    = ref_mem[idx];
        mask = (nbytes == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * nbytes)) - 1);
        if (e.err) return e;
        if (!we) begin
            v = (w >> sh) & mask;
            if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
            e.ld = v;
        end else begin
            nw = (w & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[idx] = nw;
            e.we     = 1'b1;
            e.addr   = idx[9:0];
            e.wdata  = nw;
            e.stalls = (nbytes < 4) ? 1 : 0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #3;
        last_stall = stall;
        if (rst)
            scount = 0;
        else if (!req_valid) begin
            tests++;
            if (dm_we || stall) begin
                fails++;
                $display("FAIL idle got dm_we=%0b stall=%0b expected 0 0", dm_we, stall);
            end
        end else if (stall)
            scount++;
        else begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected completion at addr %h, no expectation queued", req_addr);
            end else begin
                e = expq.pop_front();
                if (dm_we !== e.we || addr_err !== e.err || load_data !== e.ld || scount != e.stalls ||
                    (e.we && (dm_addr !== e.addr || dm_wdata !== e.wdata))) begin
                    fails++;
                    $display("FAIL txn addr=%h got we=%0b adr=%0d wd=%h ld=%h err=%0b st=%0d expected we=%0b adr=%0d wd=%h ld=%h err=%0b st=%0d",
                             req_addr, dm_we, dm_addr, dm_wdata, load_data, addr_err, scount,
                             e.we, e.addr, e.wdata, e.ld, e.err, e.stalls);
                end
            end
            scount = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        expq.push_back(model(we, sz, sg, a, wd));
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (last_stall && n < 4);
        if (last_stall) begin
            tests++;
            fails++;
            $display("FAIL timeout stall still high after %0d cycles, expected release", n);
        end
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        req_valid = 1'b0;
        poke_a = 10'(a); poke_d = d; poke_en = 1'b1;
        @(negedge clk);
        #1 poke_en = 1'b0;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, bad;
        tests = 0; fails = 0; scount = 0; cyc = 0; last_stall = 1'b0;
        poke_en = 1'b0; poke_a = '0; poke_d = '0; init_req = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h77;
        repeat (2) @(posedge clk);
        init_req = 1'b0;
        #3 check("rst_stall", 32'(stall), 0);
        check("rst_dm_we", 32'(dm_we), 0);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h12;
        #1 check("rst_addr_err", 32'(addr_err), 0);
        req_addr = 32'h10;
        #1 check("rst_load_data", load_data, 0);
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        idle();

        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 2'd2, 0, 32'h10, 32'h0);
        poke(4, 32'h11223344);
        issue(1, 2'd0, 0, 32'h12, 32'h000000AA);
        idle();
        check("sb_merge_word", mem[4], 32'h11AA3344);
        poke(4, 32'h8080F0F0);
        issue(0, 2'd0, 1, 32'h10, 0);
        issue(0, 2'd0, 0, 32'h10, 0);
        issue(0, 2'd1, 1, 32'h12, 0);
        issue(0, 2'd1, 0, 32'h12, 0);
        issue(0, 2'd3, 0, 32'h10, 0);
        issue(1, 2'd1, 0, 32'h11, 32'h1234);
        issue(0, 2'd2, 0, 32'h12, 0);
        issue(1, 2'd2, 0, 32'h1000, 32'hFFFFFFFF);
        issue(1, 2'd3, 0, 32'h14, 32'h0BADF00D);

        poke(8, 32'hCAFEF00D);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk);
        #1 rst = 1'b1;
        #2 check("rstmerge_dm_we", 32'(dm_we), 0);
        check("rstmerge_stall", 32'(stall), 0);
        @(negedge clk);
        #1 check("rstmerge_mem8", mem[8], 32'hCAFEF00D);
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        #2 check("rstmerge_stall_after", 32'(stall), 0);
        @(posedge clk);
        #1 issue(0, 2'd2, 0, 32'h20, 0);

        poke(12, 32'h0);
        t0 = cyc;
        issue(1, 2'd0, 0, 32'h30, 32'h01);
        issue(1, 2'd0, 0, 32'h31, 32'h02);
        check("b2b_cycles", 32'(cyc - t0), 4);
        idle();
        check("b2b_mem12", mem[12], 32'h00000201);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            int r;
            r = int'($urandom_range(0, 19));
            a = (r == 0) ? (32'h1000 | $urandom()) : (r < 4) ? 32'($urandom_range(0, 4095))
                                                            : 32'($urandom_range(0, 127));
            issue(1'($urandom()), 2'($urandom()), 1'($urandom()), a, $urandom());
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        idle();
        check("queue_drained", 32'(expq.size()), 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_mismatches", 32'(bad), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
